// File: rtl/joy_conditioner.sv
// joy_conditioner: synchronises, debounces and optionally autofires the two
// active-low 8-bit joystick button vectors coming from the serial decoder.
// Optional build macro: JOY_SOCD_CLEAN_EN enables per-player SOCD neutralisation
// (opposing directions pressed together are both reported as released).
module joy_conditioner #(
  parameter int unsigned TICK_DIV      = 1000,
  parameter int unsigned DEBOUNCE_N    = 4,
  parameter int unsigned AUTOFIRE_HALF = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] joy1_raw,
  input  logic [7:0] joy2_raw,
  input  logic       joy1_af_en,
  input  logic       joy2_af_en,
  output logic [7:0] joy1_out,
  output logic [7:0] joy2_out,
  output logic       sample_tick
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DbW   = (DEBOUNCE_N > 1) ? $clog2(DEBOUNCE_N) : 1;
  localparam int unsigned AfW   = (AUTOFIRE_HALF > 1) ? $clog2(AUTOFIRE_HALF) : 1;

  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_N - 1);
  localparam logic [AfW-1:0]   AfLast   = AfW'(AUTOFIRE_HALF - 1);

  // Bit offset of fire1 inside each player's byte.
  localparam int unsigned Fire1 = 4;

  // ---------------------------------------------------------------------------
  // Tick generator
  // ---------------------------------------------------------------------------
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick_q;

  // Free-running sample counter, wraps at TICK_DIV-1.
  always_comb begin
    tick_cnt_d = (tick_cnt_q == TickLast) ? '0 : tick_cnt_q + TickW'(1);
  end

  // tick_q is registered so it is high exactly while the counter holds TICK_DIV-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= (tick_cnt_d == TickLast);
    end
  end

  assign sample_tick = tick_q;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser: [15:0] buttons, [16] joy1_af_en, [17] joy2_af_en
  // ---------------------------------------------------------------------------
  logic [17:0] sync1_q, sync2_q;

  // Decoder outputs are asynchronous to clk; flops reset to the released level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {joy2_af_en, joy1_af_en, joy2_raw, joy1_raw};
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: a new level is accepted after DEBOUNCE_N consecutive differing ticks
  // ---------------------------------------------------------------------------
  logic [15:0]          stable_q, stable_d;
  logic [15:0][DbW-1:0] db_cnt_q, db_cnt_d;

  // Per-bit debounce counters, advanced only on tick cycles.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    if (tick_q) begin
      for (int i = 0; i < 16; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          // Bounce back to the stable level restarts the count.
          db_cnt_d[i] = '0;
        end else if (db_cnt_q[i] == DbLast) begin
          stable_d[i] = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  // Debounced level and counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q <= '1;
      db_cnt_q <= '0;
    end else begin
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Autofire on fire1, one engine per player
  // ---------------------------------------------------------------------------
  logic [1:0]          af_active;
  logic [1:0]          af_phase_q, af_phase_d;
  logic [1:0][AfW-1:0] af_cnt_q, af_cnt_d;

  // Phase 0 reads as pressed, so a fresh press is passed through at once.
  always_comb begin
    af_active  = '0;
    af_phase_d = af_phase_q;
    af_cnt_d   = af_cnt_q;
    for (int p = 0; p < 2; p++) begin
      af_active[p] = sync2_q[16+p] & ~stable_q[8*p+Fire1];
      if (!af_active[p]) begin
        af_phase_d[p] = 1'b0;
        af_cnt_d[p]   = '0;
      end else if (tick_q) begin
        if (af_cnt_q[p] == AfLast) begin
          af_cnt_d[p]   = '0;
          af_phase_d[p] = ~af_phase_q[p];
        end else begin
          af_cnt_d[p] = af_cnt_q[p] + AfW'(1);
        end
      end
    end
  end

  // Autofire phase and half-period counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      af_phase_q <= '0;
      af_cnt_q   <= '0;
    end else begin
      af_phase_q <= af_phase_d;
      af_cnt_q   <= af_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output conditioning and register
  // ---------------------------------------------------------------------------
  logic [15:0] cond;
  logic [15:0] out_q;

  // Build the conditioned vector from the debounced state and autofire phase.
  always_comb begin
    cond = stable_q;
    for (int p = 0; p < 2; p++) begin
      cond[8*p+Fire1] = stable_q[8*p+Fire1] | (af_active[p] & af_phase_q[p]);
`ifdef JOY_SOCD_CLEAN_EN
      // Up+down or left+right together resolve to neither pressed.
      if (!stable_q[8*p+0] && !stable_q[8*p+1]) begin
        cond[8*p+0] = 1'b1;
        cond[8*p+1] = 1'b1;
      end
      if (!stable_q[8*p+2] && !stable_q[8*p+3]) begin
        cond[8*p+2] = 1'b1;
        cond[8*p+3] = 1'b1;
      end
`endif
    end
  end

  // Registered outputs keep the PSG mux inputs glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '1;
    end else begin
      out_q <= cond;
    end
  end

  assign joy1_out = out_q[7:0];
  assign joy2_out = out_q[15:8];

endmodule
